per_bus_initiator: RTL and testbench
====================================

// Module: per_bus_initiator
// PURPOSE
//  Master-side engine for XBAR_PERIPH_BUS: turns one command (valid/ready) into a bus transaction and returns one response.
//  Sits between a local controller (DMA, debug or test sequencer) and the peripheral interconnect.
//  Tags each transaction with a rolling ID, checks r_id and r_opc, and has a timeout so a dead slave cannot hang the issuer.
// PARAMETERS
//  ADDR_WIDTH  32   bus address width
//  DATA_WIDTH  32   bus data width; BE width = DATA_WIDTH/8
//  ID_WIDTH    5    width of the id / r_id tag
//  TIMEOUT     255  cycles allowed from the first req cycle to r_valid; 0 disables the timeout
// PORTS
//  i_clk          in   1      clock
//  i_rst_n        in   1      reset: synchronous, active-low
//  i_cmd_valid    in   1      command valid
//  o_cmd_ready    out  1      command accepted (IDLE only)
//  i_cmd_addr     in   ADDR   target address
//  i_cmd_wen      in   1      1 = read, 0 = write (bus convention)
//  i_cmd_be       in   DATA/8 byte enables
//  i_cmd_wdata    in   DATA   write data
//  o_rsp_valid    out  1      response valid; held until accepted
//  i_rsp_ready    in   1      response accepted
//  o_rsp_rdata    out  DATA   read data; 0 on timeout
//  o_rsp_err      out  1      r_opc==1, or r_id mismatch, or timeout
//  o_rsp_timeout  out  1      error cause was the timeout
//  periph_master  mport -     XBAR_PERIPH_BUS.Master: req/add/wen/wdata/be/id out; gnt/r_valid/r_opc/r_id/r_rdata in
// BEHAVIOUR
//  Reset: state IDLE; req, add, wen, wdata, be, id = 0; tag = 0; o_rsp_* = 0; o_cmd_ready = 1; timer = 0.
//  FSM states: IDLE -> REQ -> WAIT -> RSP -> IDLE.
//  IDLE:
//   - o_cmd_ready=1.
//   - On i_cmd_valid: register cmd fields; id <= tag; req <= 1 the next cycle; go to REQ.
//   - r_valid is ignored here; a late response is dropped.
//  REQ:
//   - req, add, wen, wdata, be and id are held stable until gnt.
//   - On gnt: req <= 0 the next cycle; go to WAIT.
//   - tag increments (wraps modulo 2^ID_WIDTH) on every gnt.
//  WAIT:
//   - r_valid is valid no earlier than 1 cycle after gnt.
//   - On r_valid: capture r_rdata.
//   - err = r_opc | (r_id != id).
//   - Go to RSP.
//  RSP:
//   - o_rsp_valid=1 with stable data until i_rsp_ready.
//   - On i_rsp_ready: go to IDLE.
//   - Minimum cmd-accept to rsp_valid latency: 3 cycles with gnt at first req cycle and r_valid 1 cycle later.
//  Timeout:
//   - Timer clears on cmd accept and counts every cycle in REQ and WAIT.
//   - When timer==TIMEOUT and no r_valid in that cycle: drop req; go to RSP with err=1, timeout=1, rdata=0.
//   - r_valid in the same cycle as the expiry wins (normal response).
//   - A gnt in the same cycle as the expiry: still time out and do not raise req again.
//  Back-to-back: a new command is accepted only in IDLE, i.e. 1 cycle after rsp handshake.
//  Reset mid-transaction: synchronous return to the reset state; req drops on the next edge.
// STRUCTURE
//  per_bus_initiator_pkg: state enum (IDLE, REQ, WAIT, RSP) and a cmd_t struct (addr, wen, be, wdata).
//  Single module; no sub-module. FSM, tag counter and timer are in one always_ff with synchronous reset.
// TESTING
//  1 Read to a per_error_plug slave at 0x1A10_0000 -> req for 1 cycle; rsp_rdata=0xDEADBEEF; rsp_err=1; timeout=0.
//  2 Write, be=4'b0011, to a zero-wait OK slave (gnt=req, r_valid +1, opc=0) -> rsp_valid 3 cycles after accept; err=0.
//  3 Slave that withholds gnt for 4 cycles -> req, add and wdata stable for 5 cycles; tag increments only once.
//  4 TIMEOUT=8, slave never responds -> rsp_valid with err=1, timeout=1, rdata=0; a late r_valid in IDLE is ignored.
//  5 Slave returns r_id = id^1 -> err=1, timeout=0; 33 back-to-back txns check the tag wraps 31->0.
//  6 Hold i_rsp_ready=0 for 10 cycles, then assert rst_n=0 in WAIT -> rsp stays stable; after reset all outputs are 0 and cmd_ready=1.

Source files
------------

// File: rtl/per_bus_initiator_pkg.sv
// Shared types for the peripheral-bus initiator: FSM state encoding and the
// latched command record that drives the bus address/data phase.
package per_bus_initiator_pkg;

    localparam int PER_ADDR_W = 32;
    localparam int PER_DATA_W = 32;
    localparam int PER_BE_W   = PER_DATA_W / 8;
    localparam int PER_ID_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    // Field widths follow the package bus widths; the top defaults to the same.
    typedef struct packed {
        logic [PER_ADDR_W-1:0] addr;
        logic                  wen;
        logic [PER_BE_W-1:0]   be;
        logic [PER_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/xbar_periph_bus.sv
// Peripheral interconnect bus: request phase (req/gnt) followed by an
// in-order response phase (r_valid) tagged with r_id.
interface XBAR_PERIPH_BUS #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 5
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   add;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ID_WIDTH-1:0]     id;
    logic                    gnt;
    logic                    r_valid;
    logic                    r_opc;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_rdata;

    modport Master (
        output req, add, wen, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );

    modport Slave (
        input  req, add, wen, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface

// File: rtl/per_bus_initiator.sv
// Single-outstanding bus master: one command in, one bus transaction, one
// response out, with rolling ID tag, response checking and a watchdog timer.
module per_bus_initiator
    import per_bus_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = PER_ADDR_W,
    parameter int DATA_WIDTH = PER_DATA_W,
    parameter int ID_WIDTH   = PER_ID_W,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,

    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic                    i_cmd_wen,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_be,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,

    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_rsp_timeout,

    XBAR_PERIPH_BUS.Master          periph_master
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e              state;
    cmd_t                cmd_q;
    logic                req_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [ID_WIDTH-1:0] tag;
    logic [TW-1:0]       timer;
    logic                expired;

    // A zero TIMEOUT disables the watchdog entirely.
    assign expired = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));

    assign periph_master.req   = req_q;
    assign periph_master.add   = cmd_q.addr;
    assign periph_master.wen   = cmd_q.wen;
    assign periph_master.wdata = cmd_q.wdata;
    assign periph_master.be    = cmd_q.be;
    assign periph_master.id    = id_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            cmd_q         <= '0;
            req_q         <= 1'b0;
            id_q          <= '0;
            tag           <= '0;
            timer         <= '0;
            o_cmd_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Any r_valid seen here belongs to an abandoned transaction.
                    if (i_cmd_valid) begin
                        cmd_q.addr  <= i_cmd_addr;
                        cmd_q.wen   <= i_cmd_wen;
                        cmd_q.be    <= i_cmd_be;
                        cmd_q.wdata <= i_cmd_wdata;
                        id_q        <= tag;
                        req_q       <= 1'b1;
                        timer       <= '0;
                        o_cmd_ready <= 1'b0;
                        state       <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (periph_master.gnt) begin
                        tag <= tag + 1'b1;
                    end
                    // Expiry beats a coincident grant: req is not re-raised.
                    if (expired) begin
                        req_q         <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= '0;
                        o_rsp_err     <= 1'b1;
                        o_rsp_timeout <= 1'b1;
                        state         <= S_RSP;
                    end else begin
                        timer <= timer + 1'b1;
                        if (periph_master.gnt) begin
                            req_q <= 1'b0;
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (periph_master.r_valid) begin
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= periph_master.r_rdata;
                        o_rsp_err     <= periph_master.r_opc | (periph_master.r_id != id_q);
                        o_rsp_timeout <= 1'b0;
                        state         <= S_RSP;
                    end else if (expired) begin
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rdata   <= '0;
                        o_rsp_err     <= 1'b1;
                        o_rsp_timeout <= 1'b1;
                        state         <= S_RSP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid   <= 1'b0;
                        o_rsp_rdata   <= '0;
                        o_rsp_err     <= 1'b0;
                        o_rsp_timeout <= 1'b0;
                        o_cmd_ready   <= 1'b1;
                        state         <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_per_bus_initiator.sv
// Directed bench for per_bus_initiator: vector table of single transactions
// against a configurable slave model, plus reset/late-response/tag-wrap sequences.
module tb_per_bus_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 5;
    localparam int TO = 8;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
        int            gnt_dly;
        bit            respond;
        logic          opc;
        logic [IW-1:0] idx;
        logic [DW-1:0] srdata;
        int            hold;
        int            exp_lat;
        logic          exp_err;
        logic          exp_to;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          cmd_valid, cmd_ready, cmd_wen;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_be;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_to;
    logic [DW-1:0] rsp_rdata;

    XBAR_PERIPH_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    per_bus_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wen     (cmd_wen),
        .i_cmd_be      (cmd_be),
        .i_cmd_wdata   (cmd_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_to),
        .periph_master (bus.Master)
    );

    always #5 i_clk = ~i_clk;

    // Slave model: grant after gnt_dly stalled cycles, respond one cycle after grant.
    int            gnt_dly = 0;
    int            gnt_cnt = 0;
    bit            slv_respond = 1'b1;
    logic          slv_opc = 1'b0;
    logic [IW-1:0] slv_idx = '0;
    logic [DW-1:0] slv_rdata = '0;
    logic          rv_q = 1'b0, late_rv = 1'b0, opc_q = 1'b0;
    logic [IW-1:0] rid_q = '0;
    logic [DW-1:0] rdata_q = '0;

    assign bus.gnt     = bus.req && (gnt_cnt >= gnt_dly);
    assign bus.r_valid = rv_q | late_rv;
    assign bus.r_opc   = opc_q;
    assign bus.r_id    = rid_q;
    assign bus.r_rdata = rdata_q;

    always @(posedge i_clk) begin
        gnt_cnt <= (bus.req && !bus.gnt) ? gnt_cnt + 1 : 0;
        rv_q    <= bus.req && bus.gnt && slv_respond;
        rid_q   <= bus.id ^ slv_idx;
        opc_q   <= slv_opc;
        rdata_q <= slv_rdata;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [IW-1:0] exp_tag = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        int lat, reqc;
        bit field_bad, hold_bad;
        logic [IW-1:0] first_id;
        logic [DW-1:0] h_rdata;
        logic h_err, h_to;
        gnt_dly     = v.gnt_dly;
        slv_respond = v.respond;
        slv_opc     = v.opc;
        slv_idx     = v.idx;
        slv_rdata   = v.srdata;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_wen   = v.wen;
        cmd_be    = v.be;
        cmd_wdata = v.wdata;
        @(negedge i_clk);
        cmd_valid = 1'b0;
        lat = 1; reqc = 0; field_bad = 0; first_id = '0;
        while (!rsp_valid && lat < 40) begin
            if (bus.req) begin
                if (reqc == 0) first_id = bus.id;
                reqc++;
                if (bus.add !== v.addr || bus.wen !== v.wen || bus.be !== v.be ||
                    bus.wdata !== v.wdata || bus.id !== first_id)
                    field_bad = 1;
            end
            @(negedge i_clk);
            lat++;
        end
        chk("latency", lat, v.exp_lat);
        chk("req_cycles", reqc, v.gnt_dly + 1);
        chk("bus_fields_stable", {31'd0, field_bad}, 32'd0);
        chk("tag_id", {27'd0, first_id}, {27'd0, exp_tag});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk("rsp_timeout", {31'd0, rsp_to}, {31'd0, v.exp_to});
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("req_low_in_rsp", {31'd0, bus.req}, 32'd0);
        hold_bad = 0;
        h_rdata = rsp_rdata; h_err = rsp_err; h_to = rsp_to;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge i_clk);
            if (!rsp_valid || rsp_rdata !== h_rdata || rsp_err !== h_err ||
                rsp_to !== h_to || cmd_ready !== 1'b0 || bus.req !== 1'b0)
                hold_bad = 1;
        end
        if (v.hold > 0) chk("rsp_hold_stable", {31'd0, hold_bad}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge i_clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
        exp_tag = exp_tag + 1'b1;
    endtask

    function automatic vec_t mk(input logic wen, input logic [AW-1:0] addr, input logic [3:0] be,
                                input logic [DW-1:0] wdata, input int dly, input bit resp,
                                input logic opc, input logic [IW-1:0] idx, input logic [DW-1:0] srd,
                                input int hold, input int lat, input logic err, input logic to,
                                input logic [DW-1:0] erd);
        vec_t v;
        v.wen = wen; v.addr = addr; v.be = be; v.wdata = wdata; v.gnt_dly = dly;
        v.respond = resp; v.opc = opc; v.idx = idx; v.srdata = srd; v.hold = hold;
        v.exp_lat = lat; v.exp_err = err; v.exp_to = to; v.exp_rdata = erd;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        //            wen  addr          be       wdata         dly resp opc idx srdata        hold lat err to  exp_rdata
        vecs[0] = mk(1'b1, 32'h1A10_0000, 4'hF,   32'h0,        0, 1, 1'b1, 5'd0, 32'hDEADBEEF, 0,  3, 1'b1, 1'b0, 32'hDEADBEEF);
        vecs[1] = mk(1'b0, 32'h1A10_0004, 4'b0011, 32'h1234_5678, 0, 1, 1'b0, 5'd0, 32'h0,        0,  3, 1'b0, 1'b0, 32'h0);
        vecs[2] = mk(1'b0, 32'h1A20_0010, 4'b1100, 32'hA5A5_0F0F, 4, 1, 1'b0, 5'd0, 32'hCAFE_0001, 0,  7, 1'b0, 1'b0, 32'hCAFE_0001);
        vecs[3] = mk(1'b1, 32'h1A30_0000, 4'hF,   32'h0,        0, 0, 1'b0, 5'd0, 32'h5555_5555, 0, 10, 1'b1, 1'b1, 32'h0);
        vecs[4] = mk(1'b1, 32'h1A40_0008, 4'hF,   32'h0,        0, 1, 1'b0, 5'd1, 32'h0BAD_1D00, 0,  3, 1'b1, 1'b0, 32'h0BAD_1D00);
        vecs[5] = mk(1'b1, 32'h1A50_0000, 4'hF,   32'h0,        7, 1, 1'b0, 5'd0, 32'h7777_0007, 0, 10, 1'b0, 1'b0, 32'h7777_0007);
        vecs[6] = mk(1'b1, 32'h1A60_0000, 4'hF,   32'h0,        8, 1, 1'b0, 5'd0, 32'h8888_0008, 0, 10, 1'b1, 1'b1, 32'h0);
        vecs[7] = mk(1'b1, 32'h1A70_0000, 4'hF,   32'h0,        0, 1, 1'b0, 5'd0, 32'h1357_9BDF, 10, 3, 1'b0, 1'b0, 32'h1357_9BDF);

        i_rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wen = 1'b0;
        cmd_be = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_req", {31'd0, bus.req}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_bus_add", bus.add, 32'h0);
        chk("rst_bus_id", {27'd0, bus.id}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Late r_valid while idle must not produce a response.
        late_rv = 1'b1;
        @(negedge i_clk);
        late_rv = 1'b0;
        @(negedge i_clk);
        chk("late_rvalid_ignored", {31'd0, rsp_valid}, 32'd0);
        chk("late_rvalid_ready", {31'd0, cmd_ready}, 32'd1);

        // 33 back-to-back transactions: tag walks through 31 and wraps to 0.
        for (int i = 0; i < 33; i++) begin
            logic [IW-1:0] x;
            x = IW'(i % 2);
            do_txn(mk(1'b1, 32'h1B00_0000 + i * 4, 4'hF, 32'h0, 0, 1, 1'b0, x,
                      32'h100 + i, 0, 3, x[0], 1'b0, 32'h100 + i));
        end

        // Reset while waiting for a response.
        gnt_dly = 0; slv_respond = 0; slv_opc = 0; slv_idx = '0;
        cmd_valid = 1'b1; cmd_addr = 32'h1C00_0000; cmd_wen = 1'b0;
        cmd_be = 4'hF; cmd_wdata = 32'hFFFF_0000;
        @(negedge i_clk);
        cmd_valid = 1'b0;
        @(negedge i_clk);
        chk("wait_req_low", {31'd0, bus.req}, 32'd0);
        chk("wait_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_bus_add", bus.add, 32'h0);
        chk("mid_rst_bus_wdata", bus.wdata, 32'h0);
        chk("mid_rst_bus_id", {27'd0, bus.id}, 32'd0);
        exp_tag = '0;
        do_txn(mk(1'b1, 32'h1C00_0004, 4'hF, 32'h0, 0, 1, 1'b0, 5'd0, 32'h2468_ACE0,
                  0, 3, 1'b0, 1'b0, 32'h2468_ACE0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
